jtdd_char_romrq: RTL and testbench
==================================

Name: jtdd_char_romrq

Overview:
- Responder side of the character-layer ROM port: accepts the tile renderer's byte address and returns rom_data with rom_ok.
- Fetches 16-bit words from the SDRAM controller slot.
- Holds a two-entry word cache, so the two consecutive bytes of one tile row are served without a second SDRAM access.
- Sits between the character layer and the game's SDRAM arbiter.

Parameters:
- AW, 16, byte address width seen by the character layer.
- DW, 8, data width returned to the character layer; fixed at 8.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clr  input  1  cache flush (ROM download or bank change), synchronous, active-high.
- addr  input  AW  byte address from the character layer (rom_addr).
- addr_ok  input  1  address valid; high whenever the layer wants data.
- dout  output  DW  byte returned to the layer (rom_data).
- data_ok  output  1  dout is valid for the current addr (rom_ok).
- sdram_addr  output  AW-1  word address to the SDRAM slot.
- sdram_req  output  1  fetch request; held until acknowledged.
- sdram_ack  input  1  one-cycle pulse; the controller has taken the request.
- sdram_drdy  input  1  one-cycle pulse; sdram_din is valid.
- sdram_din  input  16  word read from SDRAM.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Both cache entries invalid, tags 0, data 0.
  - Replacement pointer = 0, state IDLE.
  - dout = 0, data_ok = 0, sdram_req = 0, sdram_addr = 0.
  - Reset mid-fetch abandons the fetch; a later sdram_drdy is ignored.
- Cache:
  - Two entries, each holding valid, tag[AW-2:0] and word[15:0].
  - Hit means addr_ok=1 and an entry is valid with tag == addr[AW-1:1]. The compare is combinational.
  - Byte select: addr[0]=0 gives word[7:0]; addr[0]=1 gives word[15:8].
- Output timing:
  - dout and data_ok are registered.
  - A hit in cycle N gives data_ok=1 and the selected byte on dout in cycle N+1.
  - A cycle with no hit, or with addr_ok=0, gives data_ok=0 in the next cycle. dout holds its last value.
  - When addr changes, data_ok for the new address follows the same 1-cycle rule.
- FSM:
  - IDLE: on addr_ok=1 with no hit, latch sdram_addr <= addr[AW-1:1], set sdram_req=1, go to REQ.
  - REQ: hold sdram_req and sdram_addr stable. On sdram_ack, clear sdram_req and go to WAIT.
    - If sdram_drdy arrives in the same cycle as sdram_ack, perform the fill immediately and go to IDLE.
    - sdram_drdy without a prior or simultaneous ack is ignored.
  - WAIT: on sdram_drdy, write {valid=1, tag=sdram_addr, word=sdram_din} into the entry selected by the pointer. Toggle the pointer and go to IDLE.
  - The filled address hits from the next cycle, so miss-to-data_ok latency is fill cycle + 2.
- Address change during REQ/WAIT: the in-flight fetch completes and is cached. The new addr is evaluated in IDLE afterwards.
- Duplicate fill: if the fetched tag already matches the entry not selected by the pointer, that entry is overwritten instead and the pointer does not toggle. This keeps tags unique.
- clr:
  - Invalidates both entries and resets the pointer to 0. data_ok = 0 in the next cycle.
  - If clr is asserted in REQ, the request continues until acked.
  - A fill arriving at or after a clr in REQ/WAIT is discarded, not written. The FSM still returns to IDLE.
  - clr and a hit in the same cycle: clr wins, so data_ok = 0.
- sdram_req never deasserts before sdram_ack except on reset.

Test Plan:
- Reset, then addr=0x1234 and addr_ok=1 -> sdram_req=1 with sdram_addr=0x091A. Apply ack, then drdy with din=0xBEEF -> two cycles later data_ok=1 and dout=0xEF. Then addr=0x1235 -> next cycle dout=0xBE, data_ok=1, no new sdram_req.
- Fill word 0x0010 then word 0x0020; alternate addr 0x0020/0x0040 -> every access hits with 1-cycle data_ok. Then addr=0x0060 -> a miss that replaces entry 0 (tag 0x0010); addr 0x0020 then misses.
- sdram_ack and sdram_drdy in the same cycle with din=0x5A5A -> single fill, FSM back to IDLE, data_ok=1 two cycles later with dout=0x5A.
- clr pulse during WAIT, then drdy -> no entry written and data_ok stays 0. A fresh sdram_req is issued for the still-present addr.
- rst_n=0 for one cycle during WAIT -> all outputs 0. A subsequent stray sdram_drdy causes no fill and no data_ok.
- addr changed from 0x0100 to 0x0200 while in REQ -> fetch of word 0x0080 completes and is cached. A second request for word 0x0100 is issued next, and the hit for 0x0100 follows it.

Source files
------------

// File: rtl/jtdd_char_romrq.sv
// rtl/jtdd_char_romrq.sv - character ROM responder with a two-word cache in front of an SDRAM slot
module jtdd_char_romrq #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic          addr_ok,
    output logic [DW-1:0] dout,
    output logic          data_ok,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_drdy,
    input  logic [15:0]   sdram_din
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        state;
    logic [1:0]    valid;
    logic [AW-2:0] tag  [2];
    logic [15:0]   word [2];
    logic          ptr;
    logic          discard;

    logic [AW-2:0] addr_tag;
    logic          hit0, hit1, hit;
    logic [15:0]   hit_word;
    logic [7:0]    sel_byte;
    logic          fill_now, fill_en, dup;
    logic          fill_idx;

    always_comb begin
        addr_tag = addr[AW-1:1];
        hit0     = valid[0] && (tag[0] == addr_tag);
        hit1     = valid[1] && (tag[1] == addr_tag);
        hit      = addr_ok && (hit0 || hit1);
        hit_word = hit0 ? word[0] : word[1];
        sel_byte = addr[0] ? hit_word[15:8] : hit_word[7:0];
    end

    // A refetch of a tag already held in the other entry overwrites it, keeping tags unique
    always_comb begin
        fill_now = ((state == S_WAIT) && sdram_drdy) ||
                   ((state == S_REQ) && sdram_ack && sdram_drdy);
        fill_en  = fill_now && !discard && !clr;
        dup      = valid[~ptr] && (tag[~ptr] == sdram_addr);
        fill_idx = dup ? ~ptr : ptr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            valid      <= 2'b00;
            tag[0]     <= '0;
            tag[1]     <= '0;
            word[0]    <= '0;
            word[1]    <= '0;
            ptr        <= 1'b0;
            discard    <= 1'b0;
            dout       <= '0;
            data_ok    <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else begin
            data_ok <= hit && !clr;
            if (hit && !clr) begin
                dout <= sel_byte;
            end

            case (state)
                S_IDLE: begin
                    if (addr_ok && !hit) begin
                        sdram_addr <= addr_tag;
                        sdram_req  <= 1'b1;
                        discard    <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (clr) begin
                        discard <= 1'b1;
                    end
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= sdram_drdy ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (clr) begin
                        discard <= 1'b1;
                    end
                    if (sdram_drdy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (fill_en) begin
                valid[fill_idx] <= 1'b1;
                tag[fill_idx]   <= sdram_addr;
                word[fill_idx]  <= sdram_din;
                if (!dup) begin
                    ptr <= ~ptr;
                end
            end

            if (clr) begin
                valid <= 2'b00;
                ptr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtdd_char_romrq.sv
// tb/tb_jtdd_char_romrq.sv - self-checking bench for jtdd_char_romrq
module tb_jtdd_char_romrq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] addr = '0;
    logic        addr_ok = 1'b0;
    logic [7:0]  dout;
    logic        data_ok;
    logic [14:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack = 1'b0;
    logic        sdram_drdy = 1'b0;
    logic [15:0] sdram_din = '0;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    jtdd_char_romrq #(.AW(16), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .addr       (addr),
        .addr_ok    (addr_ok),
        .dout       (dout),
        .data_ok    (data_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_drdy (sdram_drdy),
        .sdram_din  (sdram_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a two-slot FIFO-replaced word cache plus one outstanding fetch
    bit          m_valid [2] = '{0, 0};
    logic [14:0] m_tag   [2] = '{0, 0};
    logic [15:0] m_word  [2] = '{0, 0};
    int          m_ptr = 0;
    bit          m_busy = 0, m_acked = 0, m_discard = 0;
    logic [7:0]  e_dout = '0;
    bit          e_ok = 0, e_req = 0;
    logic [14:0] e_saddr = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = '{0, 0}; m_tag = '{0, 0}; m_word = '{0, 0}; m_ptr = 0;
            m_busy = 0; m_acked = 0; m_discard = 0;
            e_dout = '0; e_ok = 0; e_req = 0; e_saddr = '0;
        end else begin
            bit h;
            int e;
            h = 0; e = 0;
            for (int i = 0; i < 2; i++)
                if (m_valid[i] && m_tag[i] == addr[15:1]) begin h = 1; e = i; end
            h = h && addr_ok;
            e_ok = h && !clr;
            if (e_ok) e_dout = addr[0] ? m_word[e][15:8] : m_word[e][7:0];
            if (m_busy) begin
                if (clr) m_discard = 1;
                if (!m_acked && sdram_ack) begin m_acked = 1; e_req = 0; end
                if (m_acked && sdram_drdy) begin
                    if (!m_discard) begin
                        int o, w;
                        o = 1 - m_ptr;
                        if (m_valid[o] && m_tag[o] == e_saddr) w = o;
                        else begin w = m_ptr; m_ptr = 1 - m_ptr; end
                        m_valid[w] = 1; m_tag[w] = e_saddr; m_word[w] = sdram_din;
                    end
                    m_busy = 0;
                end
            end else if (addr_ok && !h) begin
                m_busy = 1; m_acked = 0; m_discard = 0;
                e_req = 1; e_saddr = addr[15:1];
            end
            if (clr) begin m_valid = '{0, 0}; m_ptr = 0; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_data_ok", data_ok, e_ok);
            check("model_dout", dout, e_dout);
            check("model_sdram_req", sdram_req, e_req);
            check("model_sdram_addr", sdram_addr, e_saddr);
        end
    end

    task automatic wait_req(input string name);
        int n = 0;
        while (!sdram_req && n < 50) begin @(negedge clk); n++; end
        check(name, sdram_req, 1);
    endtask

    task automatic do_ack();
        sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
    endtask

    task automatic do_drdy(input logic [15:0] d);
        sdram_drdy = 1'b1; sdram_din = d; @(negedge clk); sdram_drdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    endtask

    logic [15:0] alt_addr [4] = '{16'h0020, 16'h0041, 16'h0021, 16'h0040};
    logic [7:0]  alt_exp  [4] = '{8'hB2, 8'hC3, 8'hA1, 8'hD4};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_data_ok", data_ok, 0);
        check("rst_dout", dout, 0);
        check("rst_req", sdram_req, 0);
        check("rst_saddr", sdram_addr, 0);
        rst_n = 1'b1;

        // basic miss, fill, then the sibling byte hits
        addr = 16'h1234; addr_ok = 1'b1; @(negedge clk);
        check("t1_req", sdram_req, 1);
        check("t1_saddr", sdram_addr, 15'h091A);
        do_ack();
        check("t1_req_drop", sdram_req, 0);
        do_drdy(16'hBEEF);
        check("t1_ok_early", data_ok, 0);
        @(negedge clk);
        check("t1_ok", data_ok, 1);
        check("t1_dout", dout, 8'hEF);
        addr = 16'h1235; @(negedge clk);
        check("t1_hi_ok", data_ok, 1);
        check("t1_hi_dout", dout, 8'hBE);
        check("t1_no_req", sdram_req, 0);

        // two entries, alternating hits, then FIFO replacement
        do_reset();
        addr = 16'h0020; @(negedge clk);
        wait_req("t2_req_a"); do_ack(); do_drdy(16'hA1B2); @(negedge clk);
        addr = 16'h0040; @(negedge clk);
        wait_req("t2_req_b"); do_ack(); do_drdy(16'hC3D4); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            addr = alt_addr[i]; @(negedge clk);
            check("t2_alt_ok", data_ok, 1);
            check("t2_alt_dout", dout, alt_exp[i]);
            check("t2_alt_noreq", sdram_req, 0);
        end
        addr = 16'h0060; @(negedge clk);
        check("t2_miss_req", sdram_req, 1);
        check("t2_miss_saddr", sdram_addr, 15'h0030);
        do_ack(); do_drdy(16'hE5F6); @(negedge clk);
        check("t2_fill_ok", data_ok, 1);
        check("t2_fill_dout", dout, 8'hF6);
        addr = 16'h0040; @(negedge clk);
        check("t2_keep_ok", data_ok, 1);
        addr = 16'h0020; @(negedge clk);
        check("t2_evicted_ok", data_ok, 0);
        check("t2_evicted_req", sdram_req, 1);
        do_ack(); do_drdy(16'hA1B2); @(negedge clk);

        // ack and drdy together
        addr = 16'h0300; @(negedge clk);
        wait_req("t3_req");
        sdram_ack = 1'b1; sdram_drdy = 1'b1; sdram_din = 16'h5A5A; @(negedge clk);
        sdram_ack = 1'b0; sdram_drdy = 1'b0;
        check("t3_req_drop", sdram_req, 0);
        @(negedge clk);
        check("t3_ok", data_ok, 1);
        check("t3_dout", dout, 8'h5A);
        check("t3_no_req", sdram_req, 0);

        // clr while waiting for data discards the fill
        addr = 16'h0500; @(negedge clk);
        wait_req("t4_req"); do_ack();
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        do_drdy(16'h7777);
        check("t4_ok_a", data_ok, 0);
        @(negedge clk);
        check("t4_ok_b", data_ok, 0);
        check("t4_rereq", sdram_req, 1);
        check("t4_rereq_saddr", sdram_addr, 15'h0280);
        do_ack(); do_drdy(16'h1357); @(negedge clk);
        check("t4_ok", data_ok, 1);
        check("t4_dout", dout, 8'h57);

        // reset mid-fetch, then a stray drdy
        addr = 16'h0700; @(negedge clk);
        wait_req("t5_req"); do_ack();
        rst_n = 1'b0; addr_ok = 1'b0; @(negedge clk);
        check("t5_rst_ok", data_ok, 0);
        check("t5_rst_dout", dout, 0);
        check("t5_rst_req", sdram_req, 0);
        check("t5_rst_saddr", sdram_addr, 0);
        rst_n = 1'b1;
        do_drdy(16'h9999);
        check("t5_stray_ok", data_ok, 0);
        check("t5_stray_req", sdram_req, 0);
        addr_ok = 1'b1; @(negedge clk);
        check("t5_miss_ok", data_ok, 0);
        check("t5_miss_req", sdram_req, 1);
        check("t5_miss_saddr", sdram_addr, 15'h0380);
        do_ack(); do_drdy(16'h2468); @(negedge clk); @(negedge clk);
        check("t5_dout", dout, 8'h68);

        // address change while a request is outstanding
        addr = 16'h0100; @(negedge clk);
        check("t6_req", sdram_req, 1);
        check("t6_saddr", sdram_addr, 15'h0080);
        addr = 16'h0200; @(negedge clk);
        check("t6_saddr_hold", sdram_addr, 15'h0080);
        do_ack(); do_drdy(16'hAA55); @(negedge clk);
        check("t6_req2", sdram_req, 1);
        check("t6_saddr2", sdram_addr, 15'h0100);
        check("t6_ok_pending", data_ok, 0);
        do_ack(); do_drdy(16'hBBCC); @(negedge clk); @(negedge clk);
        check("t6_ok", data_ok, 1);
        check("t6_dout", dout, 8'hCC);
        addr = 16'h0101; @(negedge clk);
        check("t6_old_ok", data_ok, 1);
        check("t6_old_dout", dout, 8'hAA);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        check("t6_clr_wins", data_ok, 0);
        @(negedge clk);
        check("t6_clr_miss", sdram_req, 1);
        do_ack(); do_drdy(16'h0F0F);
        addr_ok = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
